// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the key-scheduling swapper and the PRGA stage.
package rc4_pkg;

  localparam int S_SIZE            = 256;
  localparam int KEY_BYTES_DEFAULT = 3;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    CP_I,
    RD_J,
    WT_J,
    CP_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

endpackage

// File: rtl/ksa_swapper_if.sv
// Control handshake and S-memory port of the KSA swapper.
interface ksa_swapper_if #(
  parameter int RAM_WIDTH = 8,
  parameter int KEY_BYTES = 3
);
  logic                   start;
  logic [KEY_BYTES*8-1:0] key;
  logic [RAM_WIDTH-1:0]   ram_q;
  logic [RAM_WIDTH-1:0]   address;
  logic [RAM_WIDTH-1:0]   ram_in;
  logic                   write_enable;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, key, ram_q,
    output address, ram_in, write_enable, busy, done
  );

  modport slave (
    output start, key, ram_q,
    input  address, ram_in, write_enable, busy, done
  );
endinterface

// File: rtl/ksa_key_mux.sv
// Selects key byte kidx from the latched key; byte 0 is the most significant byte.
module ksa_key_mux #(
  parameter int KEY_BYTES = 3,
  parameter int KIDX_W    = 2
) (
  input  logic [KEY_BYTES*8-1:0] key_lat,
  input  logic [KIDX_W-1:0]      kidx,
  output logic [7:0]             kb
);

  always_comb begin
    kb = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx == KIDX_W'(k)) kb = key_lat[(KEY_BYTES-k)*8-1 -: 8];
    end
  end

endmodule

// File: rtl/ksa_swapper.sv
// RC4 key-scheduling swap phase: owns the S-memory port, performs 256 read/read/write/write
// swap iterations of 8 cycles each, then pulses done.
module ksa_swapper
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH = 8,
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  ksa_swapper_if.master bus
);

  localparam int KEY_W  = KEY_BYTES * 8;
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  ksa_state_t             state, state_nxt;
  logic [RAM_WIDTH-1:0]   i, j, si, sj;
  logic [RAM_WIDTH-1:0]   i_nxt, j_nxt, si_nxt, sj_nxt;
  logic [KIDX_W-1:0]      kidx, kidx_nxt;
  logic [KEY_W-1:0]       key_lat, key_lat_nxt;
  logic [7:0]             kb;
  logic [RAM_WIDTH-1:0]   address_q, address_nxt;
  logic [RAM_WIDTH-1:0]   ram_in_q, ram_in_nxt;
  logic                   we_q, we_nxt, busy_q, done_q;

  ksa_key_mux #(.KEY_BYTES(KEY_BYTES), .KIDX_W(KIDX_W)) u_key_mux (
    .key_lat (key_lat),
    .kidx    (kidx),
    .kb      (kb)
  );

  always_comb begin
    state_nxt   = state;
    i_nxt       = i;
    j_nxt       = j;
    si_nxt      = si;
    sj_nxt      = sj;
    kidx_nxt    = kidx;
    key_lat_nxt = key_lat;
    case (state)
      IDLE: if (bus.start) begin
        key_lat_nxt = bus.key;
        i_nxt       = '0;
        j_nxt       = '0;
        kidx_nxt    = '0;
        state_nxt   = RD_I;
      end
      RD_I: state_nxt = WT_I;
      WT_I: state_nxt = CP_I;
      CP_I: begin
        si_nxt    = bus.ram_q;
        j_nxt     = j + bus.ram_q + RAM_WIDTH'(kb);
        state_nxt = RD_J;
      end
      RD_J: state_nxt = WT_J;
      WT_J: state_nxt = CP_J;
      CP_J: begin
        sj_nxt    = bus.ram_q;
        state_nxt = WR_I;
      end
      WR_I: state_nxt = WR_J;
      WR_J: begin
        if (i == {RAM_WIDTH{1'b1}}) begin
          state_nxt = DONE;
        end else begin
          i_nxt     = i + 1'b1;
          kidx_nxt  = (kidx == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx + 1'b1;
          state_nxt = RD_I;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the state being entered so they are valid for its whole cycle.
    address_nxt = '0;
    ram_in_nxt  = '0;
    we_nxt      = 1'b0;
    case (state_nxt)
      RD_I, WT_I, CP_I: address_nxt = i_nxt;
      RD_J, WT_J, CP_J: address_nxt = j_nxt;
      WR_I: begin
        address_nxt = i_nxt;
        ram_in_nxt  = sj_nxt;
        we_nxt      = 1'b1;
      end
      WR_J: begin
        address_nxt = j_nxt;
        ram_in_nxt  = si_nxt;
        we_nxt      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      kidx      <= '0;
      key_lat   <= '0;
      address_q <= '0;
      ram_in_q  <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      i         <= i_nxt;
      j         <= j_nxt;
      si        <= si_nxt;
      sj        <= sj_nxt;
      kidx      <= kidx_nxt;
      key_lat   <= key_lat_nxt;
      address_q <= address_nxt;
      ram_in_q  <= ram_in_nxt;
      we_q      <= we_nxt;
      busy_q    <= (state_nxt != IDLE);
      done_q    <= (state_nxt == DONE);
    end
  end

  assign bus.address      = address_q;
  assign bus.ram_in       = ram_in_q;
  assign bus.write_enable = we_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_ksa_swapper.sv
// Directed bench for ksa_swapper with a synchronous-read S-memory model and RC4 KSA reference.
module tb_ksa_swapper;

  typedef logic [7:0] sarr_t [256];

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ksa_swapper_if #(.RAM_WIDTH(8), .KEY_BYTES(3)) bus ();

  ksa_swapper #(.RAM_WIDTH(8), .KEY_BYTES(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0]  mem [256];
  logic        init_req = 1'b0;
  logic [15:0] wr_log [$];
  int          we_count = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.write_enable === 1'b1) begin
      mem[bus.address] <= bus.ram_in;
    end
    bus.ram_q <= mem[bus.address];
  end

  always @(posedge clk) begin
    if (bus.write_enable === 1'b1) begin
      wr_log.push_back({bus.address, bus.ram_in});
      we_count <= we_count + 1;
    end
  end

  function automatic sarr_t ident();
    sarr_t s;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    return s;
  endfunction

  function automatic sarr_t ksa_ref(input sarr_t s_in, input logic [23:0] k);
    sarr_t s;
    logic [7:0] jj, t;
    s  = s_in;
    jj = 8'h00;
    for (int n = 0; n < 256; n++) begin
      jj    = jj + s[n] + k[23 - 8*(n % 3) -: 8];
      t     = s[n];
      s[n]  = s[jj];
      s[jj] = t;
    end
    return s;
  endfunction

  task automatic init_mem();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
  endtask

  // Starts one run with a single-cycle start and waits (bounded) for done; returns done cycle or -1.
  task automatic run_one(input logic [23:0] k, output int dc);
    int cyc;
    @(negedge clk);
    bus.key   = k;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dc  = -1;
    cyc = 1;
    while (cyc <= 2600) begin
      if (bus.done === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.key   = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.write_enable, bus.address, bus.ram_in} !== 19'h0)
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b addr=%h din=%h, want all 0",
               bus.busy, bus.done, bus.write_enable, bus.address, bus.ram_in);
    else n_pass++;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.write_enable !== 1'b0)
      $display("FAIL idle_no_start: got busy=%b we=%b, want 0 0", bus.busy, bus.write_enable);
    else n_pass++;
  endtask

  task automatic test_first_writes();
    int dc, base, bad;
    logic [15:0] w0, w1;
    sarr_t gold;
    init_mem();
    base = wr_log.size();
    run_one(24'h030000, dc);
    w0 = (wr_log.size() > base)     ? wr_log[base]     : 16'hxxxx;
    w1 = (wr_log.size() > base + 1) ? wr_log[base + 1] : 16'hxxxx;
    n_checks++;
    if (w0 !== 16'h0003) $display("FAIL first_wr_i: got addr/data %h, want 0003", w0);
    else n_pass++;
    n_checks++;
    if (w1 !== 16'h0300) $display("FAIL first_wr_j: got addr/data %h, want 0300", w1);
    else n_pass++;
    gold = ksa_ref(ident(), 24'h030000);
    bad  = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL final_030000: got %0d wrong entries, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_zero_key();
    int dc, base, bad;
    logic [15:0] got;
    logic [15:0] exp6 [6] = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
    sarr_t gold;
    init_mem();
    base = wr_log.size();
    run_one(24'h000000, dc);
    for (int k = 0; k < 6; k++) begin
      got = (wr_log.size() > base + k) ? wr_log[base + k] : 16'hxxxx;
      n_checks++;
      if (got !== exp6[k]) $display("FAIL zero_key_wr%0d: got addr/data %h, want %h", k, got, exp6[k]);
      else n_pass++;
    end
    gold = ksa_ref(ident(), 24'h000000);
    bad  = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL final_000000: got %0d wrong entries, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_timing();
    int cyc, dc, we0, bad;
    sarr_t gold;
    init_mem();
    @(negedge clk);
    bus.key   = 24'h1F2E3D;
    bus.start = 1'b1;
    @(posedge clk);
    we0 = we_count;
    @(negedge clk);
    bus.start = 1'b0;
    dc  = -1;
    cyc = 1;
    while (1) begin
      if (cyc == 1) begin
        n_checks++;
        if (bus.busy !== 1'b1 || bus.address !== 8'h00 || bus.write_enable !== 1'b0)
          $display("FAIL cycle1_rd_i: got busy=%b addr=%h we=%b, want 1 00 0",
                   bus.busy, bus.address, bus.write_enable);
        else n_pass++;
      end
      if (cyc == 4) begin
        n_checks++;
        if (bus.address !== 8'h1F) $display("FAIL rd_j_addr: got %h, want 1f", bus.address);
        else n_pass++;
      end
      if (dc >= 0) begin
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
          $display("FAIL after_done: got done=%b busy=%b, want 0 0", bus.done, bus.busy);
        else n_pass++;
        break;
      end
      if (bus.done === 1'b1) begin
        dc = cyc;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.write_enable !== 1'b0)
          $display("FAIL done_cycle_flags: got busy=%b we=%b, want 1 0", bus.busy, bus.write_enable);
        else n_pass++;
      end
      if (cyc >= 2600) break;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (dc != 2049) $display("FAIL done_latency: got cycle %0d, want 2049", dc);
    else n_pass++;
    n_checks++;
    if (we_count - we0 != 512) $display("FAIL we_count: got %0d, want 512", we_count - we0);
    else n_pass++;
    gold = ksa_ref(ident(), 24'h1F2E3D);
    bad  = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL final_1f2e3d: got %0d wrong entries, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int dc, we0, bad;
    sarr_t gold;
    init_mem();
    @(negedge clk);
    bus.key   = 24'h0A0B0C;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (999) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.write_enable, bus.address, bus.ram_in} !== 19'h0)
      $display("FAIL async_reset: got busy=%b done=%b we=%b addr=%h din=%h, want all 0",
               bus.busy, bus.done, bus.write_enable, bus.address, bus.ram_in);
    else n_pass++;
    we0 = we_count;
    repeat (5) @(negedge clk);
    n_checks++;
    if (we_count != we0) $display("FAIL writes_in_reset: got %0d, want 0", we_count - we0);
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL idle_after_reset: got busy=%b, want 0", bus.busy);
    else n_pass++;
    init_mem();
    run_one(24'h1F2E3D, dc);
    n_checks++;
    if (dc != 2049) $display("FAIL rerun_latency: got cycle %0d, want 2049", dc);
    else n_pass++;
    gold = ksa_ref(ident(), 24'h1F2E3D);
    bad  = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL rerun_final: got %0d wrong entries, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int cyc, dc, bad;
    sarr_t gold;
    init_mem();
    @(negedge clk);
    bus.key   = 24'h1F2E3D;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dc  = -1;
    cyc = 1;
    while (cyc <= 2600) begin
      if (bus.done === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
      bus.start = (cyc == 500 || cyc == 1500);
      if (cyc == 700)  bus.key = 24'hFFFFFF;
      if (cyc == 1200) bus.key = 24'h123456;
    end
    bus.start = 1'b0;
    n_checks++;
    if (dc != 2049) $display("FAIL disturbed_latency: got cycle %0d, want 2049", dc);
    else n_pass++;
    gold = ksa_ref(ident(), 24'h1F2E3D);
    bad  = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL disturbed_final: got %0d wrong entries, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, dc2, bad;
    sarr_t gold;
    init_mem();
    @(negedge clk);
    bus.key   = 24'h0A0B0C;
    bus.start = 1'b1;
    @(negedge clk);
    bus.key = 24'h1F2E3D;
    dc2 = -1;
    cyc = 1;
    while (cyc <= 4700) begin
      if (cyc == 2049) begin
        n_checks++;
        if (bus.done !== 1'b1) $display("FAIL b2b_done1: got done=%b, want 1", bus.done);
        else n_pass++;
      end
      if (cyc == 2050) begin
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b, want 0", bus.busy);
        else n_pass++;
      end
      if (cyc == 2051) begin
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL b2b_restart: got busy=%b, want 1", bus.busy);
        else n_pass++;
        bus.start = 1'b0;
      end
      if (cyc > 2050 && bus.done === 1'b1) begin
        dc2 = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    n_checks++;
    if (dc2 != 4099) $display("FAIL b2b_done2: got cycle %0d, want 4099", dc2);
    else n_pass++;
    gold = ksa_ref(ksa_ref(ident(), 24'h0A0B0C), 24'h1F2E3D);
    bad  = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL b2b_final: got %0d wrong entries, want 0", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_writes();
    test_zero_key();
    test_timing();
    test_reset_mid_run();
    test_start_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ksa_swapper.md
Name: ksa_swapper

Overview:
- Second phase of RC4 key scheduling. Runs once the S-memory (256x8, single-port, synchronous read) holds S[i]=i.
- Iterates i=0..255 with j = j + S[i] + key[i mod KEY_BYTES] (mod 256), swapping S[i] and S[j] on every iteration.
- Owns the S-memory port while busy. Hands off to the PRGA/decrypt stage through done.

Parameters:
- RAM_WIDTH, 8, data and address width of the S-memory; depth is 2^RAM_WIDTH = 256.
- KEY_BYTES, 3, key length in bytes; the key port is KEY_BYTES*8 bits wide.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  level; sampled only in IDLE
- key  input  KEY_BYTES*8  secret key; byte 0 = key[KEY_BYTES*8-1 -: 8] (MSB first)
- ram_q  input  RAM_WIDTH  S-memory read data, valid the cycle after address is presented, then held
- address  output  RAM_WIDTH  S-memory address
- ram_in  output  RAM_WIDTH  S-memory write data
- write_enable  output  1  S-memory write strobe
- busy  output  1  high from the cycle after start is accepted through the DONE state
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; i, j, si, sj, key_lat = 0; address=0, ram_in=0, write_enable=0, busy=0, done=0. Reset mid-run abandons the run immediately; no further writes occur. The memory is left partially swapped and must be re-initialised before the next run.
- IDLE: if start=1 at the clock edge, latch key into key_lat, set i=0, j=0, go to RD_I. Otherwise stay in IDLE.
- All outputs are registered and state-decoded. Each iteration is exactly 8 states, one cycle each:
  - RD_I: address=i, write_enable=0.
  - WT_I: address=i held.
  - CP_I: si<=ram_q; j<=j+ram_q+kb, where kb = key_lat byte (i mod KEY_BYTES); 8-bit wrap, carries discarded.
  - RD_J: address=j (new value).
  - WT_J: address=j held.
  - CP_J: sj<=ram_q.
  - WR_I: address=i, ram_in=sj, write_enable=1.
  - WR_J: address=j, ram_in=si, write_enable=1. Then: if i==255 go to DONE, else i<=i+1 and go to RD_I.
- i mod KEY_BYTES is tracked by a separate wrapping counter (0..KEY_BYTES-1), reset with i. No divider.
- i==j: both writes target the same address. The final value S[i]=si, which equals sj, so the result is correct; no special case is needed.
- DONE: done=1, busy=1, write_enable=0 for exactly one cycle, then return to IDLE with done=0 and busy=0.
- Latency: start sampled at edge E0. RD_I for i=0 is cycle 1, WR_J for i=255 is cycle 2048, done is high in cycle 2049.
- start pulses while busy are ignored. If start is still high when IDLE is re-entered, a new run begins; the upstream stage drops start on done.
- Changes to key while busy have no effect, because only the latched copy is used.
- write_enable is never high outside WR_I and WR_J.
- i wraps only via the i==255 exit, so no i=256 state exists.

Decomposition:
- rc4_pkg holds:
  - S_SIZE=256
  - KEY_BYTES_DEFAULT=3
  - ksa_state_t enum: IDLE, RD_I, WT_I, CP_I, RD_J, WT_J, CP_J, WR_I, WR_J, DONE
- The PRGA stage shares the same package.
- One combinational sub-module, ksa_key_mux, selects key byte kb from key_lat and the key-index counter.
- FSM, counters and memory-port drive stay in ksa_swapper.

Test Plan:
- Memory model pre-loaded with S[i]=i, key=24'h030000, start pulse -> first writes: WR_I addr 0 data 3, then WR_J addr 3 data 0; j=3 after CP_I.
- key=24'h000000 -> i=0 and i=1 write their own value back (i==j); i=2 gives j=3, so mem[2]=3 and mem[3]=2. Final array matches the software RC4 KSA reference for this key, and for 24'h1F2E3D.
- Timing: count cycles from start accepted to done -> done high in exactly cycle 2049, for exactly 1 cycle; busy falls the following cycle; exactly 512 write_enable cycles in total.
- Assert reset_n=0 at cycle 1000 mid-run -> all outputs 0 asynchronously, no further writes; a fresh run after re-initialisation matches the golden model.
- Pulse start at cycles 500 and 1500 while busy, and toggle key mid-run -> no restart, result identical to the undisturbed run.
- Hold start high through done -> second run begins in the cycle after returning to IDLE, with the new key latched.
